// File: rtl/display_timing_pkg.sv
// rtl/display_timing_pkg.sv - shared constants and config bus layout for the display timing generator
// Contents: pixel divider width, default 640x480 timing, slot order of the timing
// fields inside the packed config bus, and a helper giving the bus width.
// Bus layout (MSB..LSB): {pcnt, vsync, vbp, vact, vfp, hsync, hbp, hact, hfp}.
package display_timing_pkg;

    localparam int PCNT_W = 3;

    localparam int DEFAULT_HSYNC = 96;
    localparam int DEFAULT_HBP   = 48;
    localparam int DEFAULT_HACT  = 640;
    localparam int DEFAULT_HFP   = 16;
    localparam int DEFAULT_VSYNC = 2;
    localparam int DEFAULT_VBP   = 33;
    localparam int DEFAULT_VACT  = 480;
    localparam int DEFAULT_VFP   = 10;
    localparam int DEFAULT_PCNT  = 1;

    // Position of a field inside one 4-field timing group (sync in the MSBs).
    typedef enum logic [1:0] {
        SLOT_FP   = 2'd0,
        SLOT_ACT  = 2'd1,
        SLOT_BP   = 2'd2,
        SLOT_SYNC = 2'd3
    } slot_e;

    function automatic int cfg_bus_w(input int pw, input int lw);
        return 4 * pw + 4 * lw + PCNT_W;
    endfunction

endpackage

// File: rtl/display_timing_cfg_shadow.sv
// rtl/display_timing_cfg_shadow.sv - validated pending/active timing configuration registers
// Ports: clk, rstn (sync active-low), en (generator enable), wrap (frame wrap cycle),
// load (capture pulse), cfg_in (packed candidate set), active_cfg (set used by the
// counters), pend (pending set waiting), err (sticky: last load rejected).
module display_timing_cfg_shadow
    import display_timing_pkg::*;
#(
    parameter int PW = 14,
    parameter int LW = 12,
    localparam int CW = cfg_bus_w(PW, LW),
    parameter logic [CW-1:0] RST_CFG = '0
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          en,
    input  logic          wrap,
    input  logic          load,
    input  logic [CW-1:0] cfg_in,
    output logic [CW-1:0] active_cfg,
    output logic          pend,
    output logic          err
);

    logic [CW-1:0] pending;
    logic          cfg_ok;

    always_comb begin
        cfg_ok = (cfg_in[CW-1 -: PCNT_W] != '0);
        for (int i = 0; i < 4; i++) begin
            if (cfg_in[i*PW +: PW] == '0) cfg_ok = 1'b0;
            if (cfg_in[4*PW + i*LW +: LW] == '0) cfg_ok = 1'b0;
        end
    end

    // Apply happens first; a load in the same cycle then refills pending, so a
    // load on the wrap cycle lands in the next frame rather than this one.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            active_cfg <= RST_CFG;
            pending    <= RST_CFG;
            pend       <= 1'b0;
            err        <= 1'b0;
        end else begin
            if (pend && (wrap || !en)) begin
                active_cfg <= pending;
                pend       <= 1'b0;
            end
            if (load) begin
                if (cfg_ok) begin
                    pending <= cfg_in;
                    pend    <= 1'b1;
                    err     <= 1'b0;
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/display_timing_prog_gen.sv
// rtl/display_timing_prog_gen.sv - programmable display timing generator
// Ports: in_pclk, in_rstn (sync active-low), in_en, in_cfg_* (timing candidate set),
// in_cfg_load (capture pulse); out_x/out_y (active coordinates), out_valid (pixel
// strobe), out_de, out_hs, out_vs, out_sof, out_eol, out_cfg_pend, out_cfg_err.
module display_timing_prog_gen
    import display_timing_pkg::*;
#(
    parameter int PW = 14,
    parameter int LW = 12,
    parameter logic HS_POL = 1'b0,
    parameter logic VS_POL = 1'b0,
    parameter logic [4*PW-1:0] DEF_H = {PW'(DEFAULT_HSYNC), PW'(DEFAULT_HBP),
                                        PW'(DEFAULT_HACT), PW'(DEFAULT_HFP)},
    parameter logic [4*LW-1:0] DEF_V = {LW'(DEFAULT_VSYNC), LW'(DEFAULT_VBP),
                                        LW'(DEFAULT_VACT), LW'(DEFAULT_VFP)},
    parameter logic [PCNT_W-1:0] DEF_PCNT = PCNT_W'(DEFAULT_PCNT)
) (
    input  logic              in_pclk,
    input  logic              in_rstn,
    input  logic              in_en,
    input  logic [PW-1:0]     in_cfg_hsync,
    input  logic [PW-1:0]     in_cfg_hbp,
    input  logic [PW-1:0]     in_cfg_hact,
    input  logic [PW-1:0]     in_cfg_hfp,
    input  logic [LW-1:0]     in_cfg_vsync,
    input  logic [LW-1:0]     in_cfg_vbp,
    input  logic [LW-1:0]     in_cfg_vact,
    input  logic [LW-1:0]     in_cfg_vfp,
    input  logic [PCNT_W-1:0] in_cfg_pcnt,
    input  logic              in_cfg_load,
    output logic [PW-1:0]     out_x,
    output logic [LW-1:0]     out_y,
    output logic              out_valid,
    output logic              out_de,
    output logic              out_hs,
    output logic              out_vs,
    output logic              out_sof,
    output logic              out_eol,
    output logic              out_cfg_pend,
    output logic              out_cfg_err
);

    localparam int CW = cfg_bus_w(PW, LW);

    logic [CW-1:0]     cfg_in, cfg_act;
    logic [PW-1:0]     hsync, hbp, hact, hfp, h_cnt;
    logic [LW-1:0]     vsync, vbp, vact, vfp, v_cnt;
    logic [PCNT_W-1:0] pcnt;
    logic [PW:0]       h_e, h_act_start, h_act_end, h_total;
    logic [LW:0]       v_e, v_act_start, v_act_end, v_total;
    logic              h_last, v_last, wrap;
    logic              raw_hs, raw_vs, raw_de, raw_first, raw_last, raw_sof;
    logic [LW-1:0]     raw_y;
    logic              s1_hs, s1_vs, s1_de, s1_first, s1_last, s1_sof;
    logic [LW-1:0]     s1_y;
    logic [PCNT_W-1:0] phase, cur_phase;

    assign cfg_in = {in_cfg_pcnt, in_cfg_vsync, in_cfg_vbp, in_cfg_vact, in_cfg_vfp,
                     in_cfg_hsync, in_cfg_hbp, in_cfg_hact, in_cfg_hfp};

    display_timing_cfg_shadow #(
        .PW      (PW),
        .LW      (LW),
        .RST_CFG ({DEF_PCNT, DEF_V, DEF_H})
    ) u_shadow (
        .clk        (in_pclk),
        .rstn       (in_rstn),
        .en         (in_en),
        .wrap       (wrap),
        .load       (in_cfg_load),
        .cfg_in     (cfg_in),
        .active_cfg (cfg_act),
        .pend       (out_cfg_pend),
        .err        (out_cfg_err)
    );

    assign hsync = cfg_act[int'(SLOT_SYNC)*PW +: PW];
    assign hbp   = cfg_act[int'(SLOT_BP)*PW +: PW];
    assign hact  = cfg_act[int'(SLOT_ACT)*PW +: PW];
    assign hfp   = cfg_act[int'(SLOT_FP)*PW +: PW];
    assign vsync = cfg_act[4*PW + int'(SLOT_SYNC)*LW +: LW];
    assign vbp   = cfg_act[4*PW + int'(SLOT_BP)*LW +: LW];
    assign vact  = cfg_act[4*PW + int'(SLOT_ACT)*LW +: LW];
    assign vfp   = cfg_act[4*PW + int'(SLOT_FP)*LW +: LW];
    assign pcnt  = cfg_act[CW-1 -: PCNT_W];

    // One extra bit keeps boundary sums from wrapping at the counter width.
    assign h_act_start = {1'b0, hsync} + {1'b0, hbp};
    assign h_act_end   = h_act_start + {1'b0, hact};
    assign h_total     = h_act_end + {1'b0, hfp};
    assign v_act_start = {1'b0, vsync} + {1'b0, vbp};
    assign v_act_end   = v_act_start + {1'b0, vact};
    assign v_total     = v_act_end + {1'b0, vfp};

    assign h_e    = {1'b0, h_cnt};
    assign v_e    = {1'b0, v_cnt};
    assign h_last = (h_e >= h_total - (PW+1)'(1));
    assign v_last = (v_e >= v_total - (LW+1)'(1));
    assign wrap   = in_en && h_last && v_last;

    always_ff @(posedge in_pclk) begin
        if (!in_rstn || !in_en) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + LW'(1);
        end else begin
            h_cnt <= h_cnt + PW'(1);
        end
    end

    assign raw_hs    = (h_e < {1'b0, hsync});
    assign raw_vs    = (v_e < {1'b0, vsync});
    assign raw_de    = (h_e >= h_act_start) && (h_e < h_act_end) &&
                       (v_e >= v_act_start) && (v_e < v_act_end);
    assign raw_first = raw_de && (h_e == h_act_start);
    assign raw_last  = raw_de && (h_e == h_act_end - (PW+1)'(1));
    assign raw_sof   = raw_first && (v_e == v_act_start);
    assign raw_y     = v_cnt - v_act_start[LW-1:0];

    // Stage 1: registered raw decode.
    always_ff @(posedge in_pclk) begin
        if (!in_rstn || !in_en) begin
            s1_hs    <= 1'b0;
            s1_vs    <= 1'b0;
            s1_de    <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_sof   <= 1'b0;
            s1_y     <= '0;
        end else begin
            s1_hs    <= raw_hs;
            s1_vs    <= raw_vs;
            s1_de    <= raw_de;
            s1_first <= raw_first;
            s1_last  <= raw_last;
            s1_sof   <= raw_sof;
            s1_y     <= raw_y;
        end
    end

    // The divider phase restarts on the first DE cycle so each line begins with a strobe.
    assign cur_phase = s1_first ? '0 : phase;

    // Stage 2: output registers, pixel strobe and x coordinate.
    always_ff @(posedge in_pclk) begin
        if (!in_rstn || !in_en) begin
            out_hs    <= ~HS_POL;
            out_vs    <= ~VS_POL;
            out_de    <= 1'b0;
            out_eol   <= 1'b0;
            out_sof   <= 1'b0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            phase     <= '0;
        end else begin
            out_hs  <= s1_hs ? HS_POL : ~HS_POL;
            out_vs  <= s1_vs ? VS_POL : ~VS_POL;
            out_de  <= s1_de;
            out_eol <= s1_last;
            out_sof <= s1_sof;
            if (!s1_de) begin
                out_valid <= 1'b0;
                out_x     <= '0;
                out_y     <= '0;
                phase     <= '0;
            end else begin
                out_y     <= s1_y;
                out_valid <= (cur_phase == '0);
                if (cur_phase == '0) out_x <= s1_first ? '0 : out_x + PW'(1);
                phase <= (cur_phase >= pcnt - PCNT_W'(1)) ? '0 : cur_phase + PCNT_W'(1);
            end
        end
    end

endmodule
